pipe_stage_skid: RTL
====================

// Module: pipe_stage_skid
// PURPOSE
//  Parametrised inter-stage pipeline register for the pipelined/multicore datapath.
//  Replaces the fixed EN/flush latch with a valid/ready handshake and an optional
//  one-entry skid buffer, so stalls are not a combinational path through the stage.
//  One instance sits between each pair of stages. Control and data travel packed in in_data.
// PARAMETERS
//  DATA_W          128  width of the packed stage payload (control + data fields)
//  SKID            1    1: two entries (main + skid), registered in_ready; 0: single entry
//  ZERO_ON_BUBBLE  1    1: an invalidated entry's data is cleared to 0; 0: data holds
// PORTS
//  CLK        in   1       clock, rising edge
//  RST        in   1       reset, asynchronous, active-high
//  flush      in   1       synchronous kill of all held entries (branch/jump mispredict)
//  in_valid   in   1       upstream beat present
//  in_ready   out  1       stage can accept a beat this cycle
//  in_data    in   DATA_W  upstream payload
//  out_valid  out  1       beat presented downstream
//  out_ready  in   1       downstream accepts this cycle
//  out_data   out  DATA_W  payload of the oldest held beat
//  occupancy  out  2       number of held beats, 0..2 (0..1 when SKID=0)
// BEHAVIOUR
//  - in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
//    Both are sampled at the rising edge of CLK.
//  - Reset: the following are forced asynchronously:
//    - out_valid=0, out_data=0, occupancy=0, internal skid data=0.
//    - in_ready=1.
//  - out_valid and out_data are register outputs. Latency from in_fire to out_valid is 1 cycle.
//  - SKID=1 states (occupancy):
//    - EMPTY(0):
//      - in_fire -> ONE, with main<=in_data.
//    - ONE(1):
//      - in_fire & out_fire -> ONE, with main<=in_data.
//      - in_fire & !out_fire -> FULL, with skid<=in_data.
//      - !in_fire & out_fire -> EMPTY.
//      - otherwise hold.
//    - FULL(2):
//      - out_fire -> ONE, with main<=skid.
//      - otherwise hold.
//    - in_ready = (occupancy!=2). It is a pure register decode; there is no combinational
//      path from out_ready.
//  - SKID=0:
//    - States EMPTY/ONE only.
//    - in_ready = !out_valid | out_ready. This is combinational from out_ready.
//    - ONE with in_fire & out_fire -> ONE, with main replaced.
//  - Ordering: beats leave strictly in arrival order. No beat is duplicated or lost
//    except by flush.
//  - flush has the highest priority.
//    - Next state is EMPTY regardless of in_fire or out_fire.
//    - An in_fire beat in the flush cycle is discarded; upstream treats it as consumed.
//    - An out_fire in the flush cycle completes normally.
//  - ZERO_ON_BUBBLE=1: any entry becoming invalid (drain, flush) has its data reg set to 0,
//    so a bubble carries RegWr/MemWr/halt=0.
//    ZERO_ON_BUBBLE=0: the data regs hold their stale value.
//  - out_data is stable while out_valid & !out_ready. It changes only on out_fire, flush or reset.
//  - Reset asserted mid-operation discards all entries immediately. Deassertion is synchronised
//    by the instantiating design.
// TESTING
//  - Stream: SKID=1, out_ready=1, push 0x1..0x8 on back-to-back cycles
//    -> out_data=0x1..0x8 on consecutive cycles, 1-cycle latency, in_ready constantly 1.
//  - Backpressure: out_ready=0, push A=0xA, B=0xB, then hold C=0xC
//    -> occupancy=2, in_ready=0, out_data=0xA held.
//    Then out_ready=1 -> out_data 0xA, 0xB, 0xC in order, no loss.
//  - Flush in FULL with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_data=0,
//    in_data beat dropped, in_ready=1.
//  - Simultaneous: occupancy=1, in_fire & out_fire -> occupancy stays 1, out_data = new beat.
//  - SKID=0: occupancy=1, out_ready=0 -> in_ready=0 the same cycle.
//    Raise out_ready -> in_ready=1 combinationally and the beat replaces main.
//  - Reset in FULL: assert RST mid-cycle -> out_valid=0, out_data=0, occupancy=0,
//    in_ready=1 without waiting for CLK.

Source files
------------

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid
// Purpose  : Valid/ready inter-stage pipeline register with an optional
//            one-entry skid buffer so stalls do not ripple combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
  parameter int unsigned DATA_W         = 128,
  parameter int unsigned SKID           = 1,
  parameter int unsigned ZERO_ON_BUBBLE = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              out_valid_q, out_valid_d;
  logic              in_fire, out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // An out_fire in this cycle has already completed; only held beats die.
      state_d = ST_EMPTY;
      if (ZERO_ON_BUBBLE != 0) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire && (SKID != 0)) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
            if (ZERO_ON_BUBBLE != 0) main_d = '0;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            if (ZERO_ON_BUBBLE != 0) skid_d = '0;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    out_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
    end
  end

  // With a skid entry, ready is decoded from state only; without one it must
  // look through to out_ready to sustain full throughput.
  generate
    if (SKID != 0) begin : g_skid_ready
      assign in_ready = (state_q != ST_FULL);
    end else begin : g_comb_ready
      assign in_ready = ~out_valid_q | out_ready;
    end
  endgenerate

  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = state_q;

endmodule
`default_nettype wire
